mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- start  in  1  request a new operation
- Funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- flush  in  1  abort the current operation
- rs1  in  32  operand A or dividend
- rs2  in  32  operand B or divisor
- busy  out  1  operation in progress; the pipeline must stall
- done  out  1  one-cycle result-valid pulse
- result  out  32  operation result

Function
REQ-003 FSM states SHALL be IDLE, CALC, SIGN and DONE.
REQ-004 IDLE SHALL sample start=1 at a clock edge, capture Funct3, rs1 and rs2, and take absolute values of the operands that Funct3 marks as signed.
REQ-005 IDLE SHALL take IDLE->CALC on start, with the iteration counter cleared to 0.
REQ-006 CALC SHALL process one operand bit per cycle for exactly 32 cycles; multiplication SHALL use shift-add into a 64-bit product and division SHALL use restoring shift-subtract.
REQ-007 CALC SHALL hold for 32 cycles, then go CALC->SIGN.
REQ-008 SIGN SHALL apply two's-complement sign correction for one cycle, then go SIGN->DONE.
- Product sign = signA XOR signB, where MULHSU treats only A as signed.
- Quotient sign = signA XOR signB.
- Remainder sign = sign of dividend.
REQ-009 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-010 Latency: if start is sampled high in cycle N, done SHALL be 1 in cycle N+34.
REQ-011 busy SHALL be 1 in cycles N+1 through N+34 inclusive.
REQ-012 result selection in DONE: MUL = product[31:0]; MULH, MULHSU and MULHU = product[63:32]; DIV and DIVU = quotient; REM and REMU = remainder.
REQ-013 Divide by zero SHALL take a fast path IDLE->DONE, with done=1 in cycle N+1.
- Quotient = 0xFFFFFFFF.
- Remainder = rs1.
REQ-014 Signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF) SHALL take the same fast path.
- Quotient = 0x80000000.
- Remainder = 0.
REQ-015 start SHALL be ignored while busy=1; no queueing.
REQ-016 start asserted in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-017 flush=1 in any non-IDLE state SHALL force IDLE at the next edge and suppress done.
REQ-018 busy SHALL be 0 in the cycle after flush is sampled.
REQ-019 flush takes priority over start and over the DONE transition.
REQ-020 result SHALL hold its last DONE value until the next DONE; flush SHALL not alter result.
REQ-021 Internal arithmetic SHALL be 33 bits wide for the division remainder and 64 bits wide for the product, with no truncation before the final selection.

Reset
REQ-022 reset=1 SHALL immediately force IDLE, busy=0, done=0, result=0, counter=0, and clear all operand/accumulator registers.
REQ-023 reset asserted mid-operation SHALL discard the operation; no done pulse follows reset release.

Structure
REQ-024 A shared package mdu_pkg SHALL hold the state enum, the eight Funct3 encodings, XLEN=32 and the iteration count constant 32.
REQ-025 One sub-module mdu_iter_step SHALL be used: a combinational single-iteration add-shift/subtract-shift step instantiated once by the FSM.

Verification
REQ-026 MUL rs1=7, rs2=0xFFFFFFFD, start in cycle N -> result=0xFFFFFFEB with done=1 in cycle N+34, busy=1 in cycles N+1..N+34.
REQ-027 MULHU rs1=rs2=0xFFFFFFFF -> result=0xFFFFFFFE; DIVU 100/7 -> 14; REMU 100/7 -> 2; DIV 0xFFFFFF9C/7 -> 0xFFFFFFF2; REM same operands -> 0xFFFFFFFE.
REQ-028 DIV rs1=0x12345678, rs2=0 -> 0xFFFFFFFF with done in cycle N+1; REM same operands -> 0x12345678.
REQ-029 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with done in N+1; REM same operands -> 0.
REQ-030 flush in cycle N+10 of a DIVU -> busy=0 in N+11, no done, result unchanged.
REQ-031 start in N+5 while busy -> ignored; the first op completes at N+34.
REQ-032 reset pulse in N+20 -> busy=0 and done=0 immediately; no done afterwards.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Holds the state enum, the Funct3 encodings and the operand-signedness decode.
package mdu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // MUL only keeps the low word, which is sign-agnostic, so it runs unsigned.
    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide) iteration.
// Multiply: {hi[31:0], lo} is the 64-bit product/multiplier; divide: hi is the remainder, lo the quotient.
module mdu_iter_step
    import mdu_pkg::*;
(
    input  logic            i_is_div,
    input  logic [XLEN:0]   i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_opb,
    output logic [XLEN:0]   o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN+1:0] w_diff;

    always_comb begin
        // hi[XLEN] is always zero in multiply mode, so the 33-bit sum cannot overflow.
        w_sum   = i_hi + (i_lo[0] ? {1'b0, i_opb} : '0);
        w_shift = {i_hi[XLEN-1:0], i_lo[XLEN-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, i_opb};
        o_hi    = {1'b0, w_sum[XLEN:1]};
        o_lo    = {w_sum[0], i_lo[XLEN-1:1]};
        if (i_is_div) begin
            if (w_diff[XLEN+1]) begin
                o_hi = w_shift;
                o_lo = {i_lo[XLEN-2:0], 1'b0};
            end else begin
                o_hi = w_diff[XLEN:0];
                o_lo = {i_lo[XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: IDLE -> CALC (32 iterations) -> SIGN -> DONE,
// with a single-cycle fast path for divide-by-zero and signed overflow.
module mdu_sequencer
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      Funct3,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mdu_state_e r_state;
    mdu_state_e w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_f3;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [XLEN:0]    r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_opb;
    logic [XLEN-1:0]  r_final;
    logic [XLEN-1:0]  r_result;

    logic             w_accept;
    logic             w_sa;
    logic             w_sb;
    logic [XLEN-1:0]  w_abs_a;
    logic [XLEN-1:0]  w_abs_b;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic [XLEN-1:0]  w_fast_val;
    logic [XLEN:0]    w_step_hi;
    logic [XLEN-1:0]  w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]  w_quo_fix;
    logic [XLEN-1:0]  w_rem_fix;
    logic [XLEN-1:0]  w_sel;

    mdu_iter_step u_step (
        .i_is_div (r_f3[2]),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opb    (r_opb),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    // Operand capture and the divide special cases, evaluated while idle.
    always_comb begin
        w_accept   = (r_state == IDLE) && start && !flush;
        w_sa       = op_signed_a(Funct3) && rs1[XLEN-1];
        w_sb       = op_signed_b(Funct3) && rs2[XLEN-1];
        w_abs_a    = w_sa ? (~rs1 + 1'b1) : rs1;
        w_abs_b    = w_sb ? (~rs2 + 1'b1) : rs2;
        w_div_zero = Funct3[2] && (rs2 == '0);
        w_div_ovf  = Funct3[2] && !Funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
        w_fast_val = Funct3[1] ? '0 : 32'h8000_0000;
        if (w_div_zero) begin
            w_fast_val = Funct3[1] ? rs1 : 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        w_prod     = {r_hi[XLEN-1:0], r_lo};
        w_prod_fix = (r_sign_a ^ r_sign_b) ? (~w_prod + 1'b1) : w_prod;
        w_quo_fix  = (r_sign_a ^ r_sign_b) ? (~r_lo + 1'b1) : r_lo;
        w_rem_fix  = r_sign_a ? (~r_hi[XLEN-1:0] + 1'b1) : r_hi[XLEN-1:0];
        w_sel      = w_prod_fix[XLEN-1:0];
        unique case (r_f3)
            F3_MUL:                        w_sel = w_prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  w_sel = w_prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               w_sel = w_quo_fix;
            F3_REM, F3_REMU:               w_sel = w_rem_fix;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_div_zero || w_div_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = SIGN;
                end
            end
            SIGN:    w_next_state = DONE;
            DONE:    w_next_state = IDLE;
        endcase
        if (flush && (r_state != IDLE)) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_f3     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_final  <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_f3     <= Funct3;
                        r_sign_a <= w_sa;
                        r_sign_b <= w_sb;
                        r_hi     <= '0;
                        r_cnt    <= '0;
                        r_lo     <= Funct3[2] ? w_abs_a : w_abs_b;
                        r_opb    <= Funct3[2] ? w_abs_b : w_abs_a;
                        r_final  <= w_fast_val;
                    end
                end
                CALC: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt + 1'b1;
                end
                SIGN:    r_final <= w_sel;
                // Commit only a completed, unflushed result so flush never disturbs it.
                DONE: begin
                    if (!flush) begin
                        r_result <= r_final;
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy   = (r_state != IDLE);
        done   = (r_state == DONE) && !flush;
        result = done ? r_final : r_result;
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer: arithmetic, latency, fast paths,
// busy/start interlock, flush and mid-operation reset.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  Funct3;
    logic        flush;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_res = 32'h0;

    always #5 clk = ~clk;

    mdu_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct3 (Funct3),
        .flush  (flush),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Start one op in cycle N, then sample each following cycle at the falling edge.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int          done_at;
        int          busy_bad;
        logic [31:0] got;
        done_at  = -1;
        busy_bad = 0;
        got      = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b1; Funct3 = f3; rs1 = a; rs2 = b;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= lat + 2; k++) begin
            if (k > 1) @(negedge clk);
            if ((k <= lat) && !busy) busy_bad++;
            if ((k > lat) && busy) busy_bad++;
            if (done && (done_at < 0)) begin
                done_at = k;
                got     = result;
            end
        end
        check_eq({tag, "_lat"}, 32'(done_at), 32'(lat));
        check_eq({tag, "_res"}, got, exp);
        check_eq({tag, "_busy"}, 32'(busy_bad), 32'd0);
        check_eq({tag, "_hold"}, result, exp);
        last_res = exp;
    endtask

    initial begin
        int first_done;
        int n_done;

        reset = 1'b1; start = 1'b0; flush = 1'b0; Funct3 = 3'b000; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        reset = 1'b0;

        run_op("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulh_p",  3'b001, 32'h4000_0000, 32'd4,         32'h0000_0001, 34);
        run_op("mulh_n",  3'b001, 32'hFFFF_FFFE, 32'h8000_0000, 32'h0000_0001, 34);
        run_op("mulhsu",  3'b010, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        run_op("divu",    3'b101, 32'd100,        32'd7,         32'd14,        34);
        run_op("remu",    3'b111, 32'd100,        32'd7,         32'd2,         34);
        run_op("div_neg", 3'b100, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 34);
        run_op("rem_neg", 3'b110, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 34);
        run_op("div_nd",  3'b100, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
        run_op("rem_nd",  3'b110, 32'd100,        32'hFFFF_FFF9, 32'd2,         34);
        run_op("div_z",   3'b100, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_z",   3'b110, 32'h1234_5678, 32'd0,         32'h1234_5678, 1);
        run_op("divu_z",  3'b101, 32'hCAFE_0001, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // start during the DONE cycle of a fast-path op is dropped
        @(negedge clk);
        start = 1'b1; Funct3 = 3'b100; rs1 = 32'h1234_5678; rs2 = 32'd0;
        @(negedge clk);
        check_eq("dz_done_n1", {31'b0, done}, 32'd1);
        start = 1'b1; Funct3 = 3'b101; rs1 = 32'd50; rs2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_in_done_busy", {31'b0, busy}, 32'd0);
        check_eq("start_in_done_res", result, 32'hFFFF_FFFF);
        last_res = 32'hFFFF_FFFF;

        // flush in N+10 of a DIVU
        @(negedge clk);
        start = 1'b1; Funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("flush_pre_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy_n11", {31'b0, busy}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("flush_no_done", 32'(n_done), 32'd0);
        check_eq("flush_result", result, last_res);

        // start in N+5 while busy is ignored
        @(negedge clk);
        start = 1'b1; Funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD;
        first_done = -1;
        n_done     = 0;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (k == 5) begin
                start = 1'b1; Funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        check_eq("busy_start_lat", 32'(first_done), 32'd34);
        check_eq("busy_start_cnt", 32'(n_done), 32'd1);
        check_eq("busy_start_res", result, 32'hFFFF_FFEB);

        // reset pulse in N+20
        @(negedge clk);
        start = 1'b1; Funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check_eq("rst_mid_pre_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_mid_done", {31'b0, done}, 32'd0);
        check_eq("rst_mid_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check_eq("rst_mid_quiet", 32'(n_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
